// File: rtl/paralelo_serial_if.sv
// ---------------------------------------------------------------------------
// paralelo_serial_if
//
// Bundles the byte-side handshake and the serial-side status of the
// parallel-to-serial converter into one connection.
//
// Signals:
//   data_in     [7:0]  parallel byte offered by the upstream mux stage
//   valid_in           data_in carries a real byte this frame
//   data_out           serial bit stream, MSB first
//   load_strobe        high during the cycle whose closing edge samples
//                      data_in / valid_in
//   active             sync preamble finished, bytes are being accepted
//   drop               one-cycle pulse: a valid byte was discarded during
//                      the sync preamble
//
// Modports:
//   master  upstream side (drives the byte, observes the serial side)
//   slave   the converter itself
// ---------------------------------------------------------------------------
interface paralelo_serial_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       load_strobe;
    logic       active;
    logic       drop;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  load_strobe,
        input  active,
        input  drop
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output load_strobe,
        output active,
        output drop
    );
endinterface

// File: rtl/paralelo_serial.sv
// ---------------------------------------------------------------------------
// paralelo_serial
//
// Serialises one byte every 8 clk_32f cycles, MSB first. After reset it sends
// SYNC_COUNT comma bytes (IDLE_CHAR) so the receiver can lock on, and only
// then starts taking bytes from upstream. Whenever no valid byte is offered
// the comma byte is sent, so the line never has gaps or bit slips.
//
// Parameters:
//   IDLE_CHAR   comma byte sent when there is nothing else to send
//   SYNC_COUNT  number of comma bytes in the post-reset preamble (1..15)
//
// Ports:
//   clk_32f  bit clock, every state change happens on its rising edge
//   reset    asynchronous, active-high, clears everything immediately
//   bus      paralelo_serial_if.slave (data_in, valid_in, data_out,
//            load_strobe, active, drop)
// ---------------------------------------------------------------------------
module paralelo_serial #(
    parameter logic [7:0]  IDLE_CHAR  = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic           clk_32f,
    input  logic           reset,
    paralelo_serial_if.slave bus
);

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT);

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [3:0] sync_cnt;
    logic       drop_q;

    logic       load_edge;
    logic [7:0] next_byte;
    logic [3:0] sync_cnt_inc;

    // The edge that closes a cycle with bit_cnt == 7 is the frame boundary:
    // it loads a fresh byte instead of shifting. Upstream data only counts
    // once the preamble is over; until then the comma byte is forced.
    always_comb begin
        load_edge    = (bit_cnt == 3'd7);
        next_byte    = IDLE_CHAR;
        sync_cnt_inc = sync_cnt + 4'd1;
        if (state == ACTIVE && bus.valid_in) begin
            next_byte = bus.data_in;
        end
    end

    // Shift register, bit counter and the SYNC/ACTIVE state machine.
    // Reset parks bit_cnt at 7 so the very first edge after release is a
    // load edge and starts the first preamble comma without a partial frame.
    // In SYNC every load edge counts one comma; the load edge that reaches
    // SYNC_COUNT still sends a comma and only the following frame may carry
    // data. A valid byte offered during any SYNC load is reported on drop.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state    <= SYNC;
            shreg    <= 8'h00;
            bit_cnt  <= 3'd7;
            sync_cnt <= 4'd0;
            drop_q   <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            drop_q  <= 1'b0;
            if (load_edge) begin
                shreg <= next_byte;
                if (state == SYNC) begin
                    sync_cnt <= sync_cnt_inc;
                    drop_q   <= bus.valid_in;
                    if (sync_cnt_inc == SYNC_LAST) begin
                        state <= ACTIVE;
                    end
                end
            end else begin
                shreg <= {shreg[6:0], 1'b0};
            end
        end
    end

    // All outputs come straight from registers (load_strobe from bit_cnt
    // only), so nothing on the serial side depends combinationally on the
    // upstream byte.
    assign bus.data_out    = shreg[7];
    assign bus.load_strobe = load_edge;
    assign bus.active      = (state == ACTIVE);
    assign bus.drop        = drop_q;

endmodule

// File: tb/tb_paralelo_serial.sv
// ---------------------------------------------------------------------------
// tb_paralelo_serial
//
// Bench for paralelo_serial. Two instances share clock and reset: dut0 with
// the default 4-comma preamble and dut1 with a single-comma preamble. Each
// test pushes the bits it expects on data_out into a per-instance queue when
// it drives a frame; a monitor pops and compares one bit after every rising
// edge. Status outputs are compared inline on the falling edge.
// ---------------------------------------------------------------------------
module tb_paralelo_serial;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    int checks = 0;
    int errors = 0;

    bit q0[$];
    bit q1[$];
    bit exp0;
    bit exp1;

    paralelo_serial_if bus0();
    paralelo_serial_if bus1();

    paralelo_serial #(.IDLE_CHAR(8'hBC), .SYNC_COUNT(4)) dut0 (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus0)
    );

    paralelo_serial #(.IDLE_CHAR(8'hBC), .SYNC_COUNT(1)) dut1 (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus1)
    );

    // 10 time-unit bit clock.
    always #5 clk_32f = ~clk_32f;

    // Serial scoreboard for dut0: one expected bit per rising edge while
    // anything is queued, sampled 1 unit after the edge.
    always @(posedge clk_32f) begin
        #1;
        if (!reset && q0.size() > 0) begin
            exp0 = q0.pop_front();
            checks++;
            if (bus0.data_out !== exp0) begin
                errors++;
                $display("[TB] FAIL dut0_serial @%0t: data_out=%b expected=%b", $time, bus0.data_out, exp0);
            end
        end
    end

    // Same scoreboard for dut1.
    always @(posedge clk_32f) begin
        #1;
        if (!reset && q1.size() > 0) begin
            exp1 = q1.pop_front();
            checks++;
            if (bus1.data_out !== exp1) begin
                errors++;
                $display("[TB] FAIL dut1_serial @%0t: data_out=%b expected=%b", $time, bus1.data_out, exp1);
            end
        end
    end

    // Guard against a stuck run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Queue the 8 bits of a byte, MSB first.
    task automatic push0(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) q0.push_back(b[i]);
    endtask

    task automatic push1(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) q1.push_back(b[i]);
    endtask

    // Pulse reset for two cycles and release on a falling edge, so the next
    // rising edge is edge 1 after reset.
    task automatic do_reset(input logic v, input logic [7:0] d);
        @(negedge clk_32f);
        reset         = 1'b1;
        bus0.valid_in = v;
        bus0.data_in  = d;
        bus1.valid_in = 1'b0;
        bus1.data_in  = 8'h00;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk_32f);
        reset = 1'b0;
    endtask

    // Outputs of both instances while reset is held.
    task automatic test_reset();
        bus0.valid_in = 1'b0;
        bus0.data_in  = 8'h00;
        bus1.valid_in = 1'b0;
        bus1.data_in  = 8'h00;
        reset         = 1'b1;
        #22;
        checks++; if (bus0.data_out !== 1'b0)    begin errors++; $display("[TB] FAIL reset_data_out: got=%b expected=0", bus0.data_out); end
        checks++; if (bus0.load_strobe !== 1'b1) begin errors++; $display("[TB] FAIL reset_load_strobe: got=%b expected=1", bus0.load_strobe); end
        checks++; if (bus0.active !== 1'b0)      begin errors++; $display("[TB] FAIL reset_active: got=%b expected=0", bus0.active); end
        checks++; if (bus0.drop !== 1'b0)        begin errors++; $display("[TB] FAIL reset_drop: got=%b expected=0", bus0.drop); end
        checks++; if (bus1.data_out !== 1'b0)    begin errors++; $display("[TB] FAIL reset_data_out_1: got=%b expected=0", bus1.data_out); end
        checks++; if (bus1.load_strobe !== 1'b1) begin errors++; $display("[TB] FAIL reset_load_strobe_1: got=%b expected=1", bus1.load_strobe); end
        checks++; if (bus1.active !== 1'b0)      begin errors++; $display("[TB] FAIL reset_active_1: got=%b expected=0", bus1.active); end
    endtask

    // Four commas after reset with nothing offered; active after edge 25,
    // load_strobe after every 8th edge.
    task automatic test_sync_preamble();
        do_reset(1'b0, 8'h00);
        repeat (4) push0(8'hBC);
        for (int e = 1; e <= 32; e++) begin
            @(negedge clk_32f);
            checks++;
            if (bus0.active !== (e >= 25)) begin
                errors++; $display("[TB] FAIL preamble_active edge %0d: got=%b expected=%b", e, bus0.active, (e >= 25));
            end
            checks++;
            if (bus0.load_strobe !== (e % 8 == 0)) begin
                errors++; $display("[TB] FAIL preamble_load_strobe edge %0d: got=%b expected=%b", e, bus0.load_strobe, (e % 8 == 0));
            end
            checks++;
            if (bus0.drop !== 1'b0) begin
                errors++; $display("[TB] FAIL preamble_drop edge %0d: got=%b expected=0", e, bus0.drop);
            end
        end
    endtask

    // One data byte followed by commas.
    task automatic test_single_byte();
        bus0.data_in  = 8'hEE;
        bus0.valid_in = 1'b1;
        push0(8'hEE);
        push0(8'hBC);
        push0(8'hBC);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk_32f);
            if (c == 0) begin
                bus0.valid_in = 1'b0;
                bus0.data_in  = 8'h33;
            end
            checks++;
            if (bus0.active !== 1'b1 || bus0.drop !== 1'b0) begin
                errors++; $display("[TB] FAIL single_status c=%0d: active=%b drop=%b expected active=1 drop=0", c, bus0.active, bus0.drop);
            end
        end
    endtask

    // Four valid bytes on consecutive frames, then a comma.
    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        bytes[0] = 8'hEE; bytes[1] = 8'hEF; bytes[2] = 8'hF0; bytes[3] = 8'hF1;
        for (int i = 0; i < 4; i++) push0(bytes[i]);
        push0(8'hBC);
        bus0.data_in  = bytes[0];
        bus0.valid_in = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_32f);
            if (c % 8 == 7) begin
                if (c / 8 < 3) bus0.data_in = bytes[c / 8 + 1];
                else           bus0.valid_in = 1'b0;
            end
            checks++;
            if (bus0.drop !== 1'b0) begin
                errors++; $display("[TB] FAIL b2b_drop c=%0d: got=%b expected=0", c, bus0.drop);
            end
        end
    endtask

    // valid_in held high from reset release: commas with a drop pulse after
    // each preamble load, then the held byte.
    task automatic test_drop_preamble();
        do_reset(1'b1, 8'hFF);
        repeat (4) push0(8'hBC);
        push0(8'hFF);
        push0(8'hBC);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk_32f);
            if (c == 32) bus0.valid_in = 1'b0;
            checks++;
            if (bus0.drop !== (c % 8 == 0 && c < 32)) begin
                errors++; $display("[TB] FAIL drop_pulse c=%0d: got=%b expected=%b", c, bus0.drop, (c % 8 == 0 && c < 32));
            end
            checks++;
            if (bus0.active !== (c >= 24)) begin
                errors++; $display("[TB] FAIL drop_active c=%0d: got=%b expected=%b", c, bus0.active, (c >= 24));
            end
        end
    endtask

    // Reset during bit 4 of a data frame, then the full preamble again.
    task automatic test_reset_mid_frame();
        bus0.data_in  = 8'hA5;
        bus0.valid_in = 1'b1;
        push0(8'hA5);
        repeat (4) @(negedge clk_32f);
        @(posedge clk_32f);
        #2;
        reset = 1'b1;
        #1;
        q0.delete();
        q1.delete();
        checks++; if (bus0.data_out !== 1'b0)    begin errors++; $display("[TB] FAIL midreset_data_out: got=%b expected=0", bus0.data_out); end
        checks++; if (bus0.load_strobe !== 1'b1) begin errors++; $display("[TB] FAIL midreset_load_strobe: got=%b expected=1", bus0.load_strobe); end
        checks++; if (bus0.active !== 1'b0)      begin errors++; $display("[TB] FAIL midreset_active: got=%b expected=0", bus0.active); end
        bus0.data_in = 8'hFD;
        repeat (2) @(negedge clk_32f);
        reset = 1'b0;
        repeat (4) push0(8'hBC);
        push0(8'hFD);
        push0(8'hBC);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk_32f);
            if (c == 32) bus0.valid_in = 1'b0;
            checks++;
            if (bus0.active !== (c >= 24) || bus0.drop !== (c % 8 == 0 && c < 32)) begin
                errors++; $display("[TB] FAIL midreset_status c=%0d: active=%b drop=%b expected active=%b drop=%b",
                                   c, bus0.active, bus0.drop, (c >= 24), (c % 8 == 0 && c < 32));
            end
        end
    endtask

    // Single-comma preamble on dut1; inputs scrambled between load edges
    // must not disturb the stream.
    task automatic test_short_sync();
        do_reset(1'b0, 8'h00);
        push1(8'hBC);
        push1(8'h5A);
        push1(8'hBC);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk_32f);
            if (c % 8 == 7) begin
                if (c / 8 == 0) begin
                    bus1.data_in  = 8'h5A;
                    bus1.valid_in = 1'b1;
                end else begin
                    bus1.data_in  = 8'($urandom);
                    bus1.valid_in = 1'b0;
                end
            end else begin
                bus1.data_in  = 8'($urandom);
                bus1.valid_in = 1'($urandom);
            end
            checks++;
            if (bus1.active !== 1'b1 || bus1.drop !== 1'b0) begin
                errors++; $display("[TB] FAIL short_sync_status c=%0d: active=%b drop=%b expected active=1 drop=0", c, bus1.active, bus1.drop);
            end
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++; $display("[TB] FAIL scoreboard_drain: left=%0d/%0d expected=0/0", q0.size(), q1.size());
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_sync_preamble();
        test_single_byte();
        test_back_to_back();
        test_drop_preamble();
        test_reset_mid_frame();
        test_short_sync();
        @(negedge clk_32f);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
